// File: rtl/mii_tx_arbiter.sv
// Two-source MII transmit arbiter: per-frame round-robin grant, preamble/SFD generation,
// low-nibble-first serialisation, inter-frame gap, and underflow error/flush handling.
module mii_tx_arbiter #(
    parameter int IPG_NIBBLES      = 24,
    parameter int PREAMBLE_NIBBLES = 15
) (
    input  logic        mac_mii_txc,
    input  logic        rstn,
    input  logic [1:0]  req_valid,
    input  logic [15:0] req_data,
    input  logic [1:0]  req_last,
    input  logic [1:0]  req_err,
    output logic [1:0]  req_ready,
    output logic        mac_mii_txen,
    output logic        mac_mii_txer,
    output logic [3:0]  mac_mii_txd,
    output logic [1:0]  grant,
    output logic        underflow
);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_SFD, S_DLO, S_DHI, S_FLUSH, S_IPG
    } state_t;

    localparam logic [7:0] PRE_LOAD = 8'(PREAMBLE_NIBBLES - 1);
    localparam logic [7:0] IPG_LOAD = 8'(IPG_NIBBLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  grant_q, grant_d;
    logic        last_grant_q, last_grant_d;
    logic [7:0]  byte_q, byte_d;
    logic        blast_q, blast_d;
    logic        berr_q, berr_d;
    logic        txen_q, txen_d;
    logic        txer_q, txer_d;
    logic [3:0]  txd_q, txd_d;
    logic        uf_q, uf_d;

    logic        gidx;
    logic        own_valid;
    logic        own_last;
    logic        own_err;
    logic [7:0]  own_data;
    logic        any_req;
    logic        winner;

    assign gidx      = grant_q[1];
    assign own_valid = gidx ? req_valid[1] : req_valid[0];
    assign own_last  = gidx ? req_last[1]  : req_last[0];
    assign own_err   = gidx ? req_err[1]   : req_err[0];
    assign own_data  = gidx ? req_data[15:8] : req_data[7:0];
    assign any_req   = |req_valid;
    // On a tie the source that did not win last time goes next.
    assign winner    = (&req_valid) ? ~last_grant_q : req_valid[1];

    always_ff @(posedge mac_mii_txc) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            grant_q      <= '0;
            last_grant_q <= 1'b1;
            byte_q       <= '0;
            blast_q      <= 1'b0;
            berr_q       <= 1'b0;
            txen_q       <= 1'b0;
            txer_q       <= 1'b0;
            txd_q        <= '0;
            uf_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            byte_q       <= byte_d;
            blast_q      <= blast_d;
            berr_q       <= berr_d;
            txen_q       <= txen_d;
            txer_q       <= txer_d;
            txd_q        <= txd_d;
            uf_q         <= uf_d;
        end
    end

    always_comb begin
        logic do_arb;
        logic take;
        do_arb       = 1'b0;
        take         = 1'b0;
        state_d      = state_q;
        cnt_d        = cnt_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        byte_d       = byte_q;
        blast_d      = blast_q;
        berr_d       = berr_q;
        uf_d         = 1'b0;
        case (state_q)
            S_IDLE: do_arb = any_req;
            S_PRE: begin
                if (cnt_q == 8'd0) state_d = S_SFD;
                else               cnt_d   = cnt_q - 8'd1;
            end
            S_SFD: begin
                if (own_valid) take = 1'b1;
                else begin
                    uf_d    = 1'b1;
                    state_d = S_FLUSH;
                end
            end
            S_DLO: state_d = S_DHI;
            S_DHI: begin
                if (blast_q) begin
                    state_d = S_IPG;
                    grant_d = '0;
                    cnt_d   = IPG_LOAD;
                end else if (own_valid) begin
                    take = 1'b1;
                end else begin
                    uf_d    = 1'b1;
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (own_valid && own_last) begin
                    state_d = S_IPG;
                    grant_d = '0;
                    cnt_d   = IPG_LOAD;
                end
            end
            S_IPG: begin
                if (cnt_q == 8'd0) begin
                    do_arb = any_req;
                    if (!any_req) state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (take) begin
            byte_d  = own_data;
            blast_d = own_last;
            berr_d  = own_err;
            state_d = S_DLO;
        end
        if (do_arb) begin
            state_d      = S_PRE;
            cnt_d        = PRE_LOAD;
            grant_d      = winner ? 2'b10 : 2'b01;
            last_grant_d = winner;
        end
    end

    // Pin values are computed from the next state so they appear with that state, registered.
    always_comb begin
        txen_d    = 1'b0;
        txer_d    = 1'b0;
        txd_d     = 4'h0;
        req_ready = 2'b00;
        if (uf_d) begin
            txen_d = 1'b1;
            txer_d = 1'b1;
        end else begin
            case (state_d)
                S_PRE: begin
                    txen_d = 1'b1;
                    txd_d  = 4'h5;
                end
                S_SFD: begin
                    txen_d = 1'b1;
                    txd_d  = 4'hD;
                end
                S_DLO: begin
                    txen_d = 1'b1;
                    txd_d  = byte_d[3:0];
                    txer_d = berr_d;
                end
                S_DHI: begin
                    txen_d = 1'b1;
                    txd_d  = byte_d[7:4];
                    txer_d = berr_d;
                end
                default: ;
            endcase
        end
        case (state_q)
            S_SFD, S_FLUSH: req_ready = grant_q;
            S_DHI:          req_ready = blast_q ? 2'b00 : grant_q;
            default:        req_ready = 2'b00;
        endcase
    end

    assign mac_mii_txen = txen_q;
    assign mac_mii_txer = txer_q;
    assign mac_mii_txd  = txd_q;
    assign grant        = grant_q;
    assign underflow    = uf_q;

endmodule

// File: tb/tb_mii_tx_arbiter.sv
// Directed bench for mii_tx_arbiter: table of expected wire frames plus hand-written
// underflow and mid-frame reset sequences.
module tb_mii_tx_arbiter;

    localparam int PRE = 15;

    logic        clk = 1'b0;
    logic        rstn;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  req_err;
    logic [1:0]  req_ready;
    logic        mac_mii_txen;
    logic        mac_mii_txer;
    logic [3:0]  mac_mii_txd;
    logic [1:0]  grant;
    logic        underflow;

    always #5 clk = ~clk;

    mii_tx_arbiter #(.IPG_NIBBLES(24), .PREAMBLE_NIBBLES(PRE)) dut (
        .mac_mii_txc (clk),
        .rstn        (rstn),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_err     (req_err),
        .req_ready   (req_ready),
        .mac_mii_txen(mac_mii_txen),
        .mac_mii_txer(mac_mii_txer),
        .mac_mii_txd (mac_mii_txd),
        .grant       (grant),
        .underflow   (underflow)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       last;
        logic       err;
    } beat_t;

    typedef struct {
        int          phase;
        int          src;
        int          nb;
        logic [31:0] bytes;
        logic [3:0]  errm;
        logic [1:0]  exp_grant;
        int          exp_gap;
    } vec_t;

    beat_t q0[$];
    beat_t q1[$];
    vec_t  vecs[8];
    logic [1:0] drv_acc;
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int s, input logic [7:0] d, input logic last, input logic err);
        beat_t b;
        b.d = d;
        b.last = last;
        b.err = err;
        if (s == 0) q0.push_back(b);
        else        q1.push_back(b);
    endtask

    // Source model: presents queue heads at negedge, pops what the DUT accepted at the posedge.
    initial begin
        drv_acc   = 2'b00;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        req_err   = '0;
        forever begin
            @(negedge clk);
            if (drv_acc[0] && q0.size() != 0) void'(q0.pop_front());
            if (drv_acc[1] && q1.size() != 0) void'(q1.pop_front());
            req_valid[0] = (q0.size() != 0);
            if (q0.size() != 0) begin
                req_data[7:0] = q0[0].d;
                req_last[0]   = q0[0].last;
                req_err[0]    = q0[0].err;
            end else begin
                req_data[7:0] = '0;
                req_last[0]   = 1'b0;
                req_err[0]    = 1'b0;
            end
            req_valid[1] = (q1.size() != 0);
            if (q1.size() != 0) begin
                req_data[15:8] = q1[0].d;
                req_last[1]    = q1[0].last;
                req_err[1]     = q1[0].err;
            end else begin
                req_data[15:8] = '0;
                req_last[1]    = 1'b0;
                req_err[1]     = 1'b0;
            end
            drv_acc = req_valid & req_ready & {2{rstn}};
        end
    end

    task automatic wait_txen(input string name, output int low);
        bit seen;
        seen = 1'b0;
        low  = 0;
        for (int n = 0; n < 3000 && !seen; n++) begin
            @(negedge clk);
            if (mac_mii_txen) seen = 1'b1;
            else              low++;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: txen got 0 for %0d cycles expected 1", name, low);
        end
    endtask

    // Called at the negedge showing the first preamble nibble; returns at the last data nibble.
    task automatic check_frame(input string name, input logic [1:0] g, input int nb,
                               input logic [31:0] bytes, input logic [3:0] errm);
        int         bad;
        logic [3:0] en;
        logic       ee;
        logic [7:0] b;
        logic [8:0] act, exp;
        int         k;
        bad = 0;
        for (int i = 0; i < PRE + 1 + 2 * nb; i++) begin
            if (i > 0) @(negedge clk);
            ee = 1'b0;
            if (i < PRE)       en = 4'h5;
            else if (i == PRE) en = 4'hD;
            else begin
                k  = (i - PRE - 1) / 2;
                b  = bytes[8 * k +: 8];
                en = ((i - PRE - 1) % 2 == 0) ? b[3:0] : b[7:4];
                ee = errm[k];
            end
            act = {mac_mii_txen, mac_mii_txer, mac_mii_txd, grant, underflow};
            exp = {1'b1, ee, en, g, 1'b0};
            if (act !== exp) begin
                if (bad == 0)
                    $display("  %s first diff at nibble %0d: {txen,txer,txd,grant,uf} got %b want %b",
                             name, i, act, exp);
                bad++;
            end
        end
        chk({name, "_nibble_errors"}, 32'(bad), 32'd0);
    endtask

    initial begin
        int low;
        rstn = 1'b0;
        vecs[0] = '{0, 0, 2, 32'h0000_4321, 4'b0000, 2'b01, -1};
        vecs[1] = '{1, 0, 2, 32'h0000_2211, 4'b0000, 2'b01, -1};
        vecs[2] = '{1, 1, 2, 32'h0000_4433, 4'b0000, 2'b10, 24};
        vecs[3] = '{1, 0, 2, 32'h0000_6655, 4'b0000, 2'b01, 24};
        vecs[4] = '{1, 1, 2, 32'h0000_8877, 4'b0000, 2'b10, 24};
        vecs[5] = '{2, 1, 3, 32'h0054_3210, 4'b0010, 2'b10, -1};
        vecs[6] = '{3, 0, 1, 32'h0000_00A5, 4'b0000, 2'b01, -1};
        vecs[7] = '{3, 0, 1, 32'h0000_00A5, 4'b0000, 2'b01, 24};

        repeat (3) @(negedge clk);
        chk("reset_outputs",
            32'({mac_mii_txen, mac_mii_txer, mac_mii_txd, grant, underflow, req_ready}), 32'd0);
        #2 rstn = 1'b1;

        for (int p = 0; p < 4; p++) begin
            @(negedge clk);
            #2;
            if (p == 1) rstn = 1'b0;
            for (int v = 0; v < 8; v++)
                if (vecs[v].phase == p)
                    for (int k = 0; k < vecs[v].nb; k++)
                        push(vecs[v].src, vecs[v].bytes[8 * k +: 8], k == vecs[v].nb - 1,
                             vecs[v].errm[k]);
            if (p == 1) begin
                @(negedge clk);
                #2 rstn = 1'b1;
            end
            for (int v = 0; v < 8; v++) begin
                if (vecs[v].phase == p) begin
                    wait_txen($sformatf("vec%0d", v), low);
                    if (vecs[v].exp_gap >= 0)
                        chk($sformatf("vec%0d_gap", v), 32'(low), 32'(vecs[v].exp_gap));
                    check_frame($sformatf("vec%0d", v), vecs[v].exp_grant, vecs[v].nb,
                                vecs[v].bytes, vecs[v].errm);
                end
            end
            if (p == 0) begin
                @(negedge clk);
                chk("single_frame_end", 32'({mac_mii_txen, grant}), 32'd0);
            end
            repeat (40) @(negedge clk);
        end

        // Underflow: 0x10 then nothing at the DHI ready; the tail bytes are queued behind.
        #2 push(0, 8'h10, 1'b0, 1'b0);
        wait_txen("uf", low);
        check_frame("uf_head", 2'b01, 1, 32'h10, 4'b0000);
        #2;
        push(0, 8'h01, 1'b0, 1'b0);
        push(0, 8'h02, 1'b0, 1'b0);
        push(0, 8'h03, 1'b1, 1'b0);
        push(0, 8'hA5, 1'b1, 1'b0);
        @(negedge clk);
        chk("uf_error_nibble", 32'({underflow, mac_mii_txen, mac_mii_txer, mac_mii_txd}), 32'h70);
        chk("uf_grant_held", 32'(grant), 32'h1);
        @(negedge clk);
        chk("uf_after", 32'({underflow, mac_mii_txen, mac_mii_txer, mac_mii_txd}), 32'h0);
        // Three flush cycles (the error nibble cycle is one) precede the 24-cycle gap.
        wait_txen("uf_next", low);
        chk("uf_gap", 32'(low), 32'd25);
        check_frame("uf_next", 2'b01, 1, 32'hA5, 4'b0000);

        // Reset during the low nibble of the third byte.
        repeat (40) @(negedge clk);
        #2;
        push(0, 8'h11, 1'b0, 1'b0);
        push(0, 8'h22, 1'b0, 1'b0);
        push(0, 8'h33, 1'b0, 1'b0);
        push(0, 8'h44, 1'b1, 1'b0);
        wait_txen("rst", low);
        check_frame("rst_head", 2'b01, 2, 32'h2211, 4'b0000);
        @(negedge clk);
        chk("rst_dlo", 32'({mac_mii_txen, mac_mii_txd}), 32'h13);
        #2 rstn = 1'b0;
        @(negedge clk);
        chk("rst_outputs",
            32'({mac_mii_txen, mac_mii_txer, mac_mii_txd, grant, underflow, req_ready}), 32'd0);
        #2;
        rstn = 1'b1;
        q0.delete();
        push(0, 8'h5A, 1'b1, 1'b0);
        wait_txen("rst_new", low);
        check_frame("rst_new", 2'b01, 1, 32'h5A, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mii_tx_arbiter.md
# mii_tx_arbiter

Shares the MAC-side MII transmit port of `rmii_phy_if` between two byte-stream frame sources. It runs in the `mac_mii_txc` domain, grants one source per frame by round-robin, and generates preamble/SFD. It serialises each byte low nibble first onto `mac_mii_txd` and enforces the inter-frame gap. Mid-frame source underflow is flagged to the PHY with `mac_mii_txer` and the rest of that frame is flushed.

## Interface
- `IPG_NIBBLES`, 24: minimum txen-low cycles between frames (range 2..255).
- `PREAMBLE_NIBBLES`, 15: count of 0x5 nibbles before the 0xD SFD (range 1..15).

- `mac_mii_txc`, in, 1: the single clock; all logic on its rising edge.
- `rstn`, in, 1: reset, synchronous and active-low (drive from `~mac_mii_txrst` or system reset).
- `req_valid`, in, 2: per-source byte valid.
- `req_data`, in, 16: per-source byte; [7:0] is source 0, [15:8] is source 1.
- `req_last`, in, 2: byte is the last of its frame.
- `req_err`, in, 2: byte is to be sent with txer.
- `req_ready`, out, 2: byte accepted when valid&ready; combinational from state only, never from valid.
- `mac_mii_txen`, out, 1: registered MII tx enable.
- `mac_mii_txer`, out, 1: registered MII tx error.
- `mac_mii_txd`, out, 4: registered MII tx data.
- `grant`, out, 2: one-hot owner, held from decision to the end of the frame/flush, 0 otherwise.
- `underflow`, out, 1: one-cycle pulse when an underflow is detected.

## Operation
- States: IDLE, PRE, SFD, DLO, DHI, FLUSH, IPG.
- **IDLE**
  - If any `req_valid` is high, arbitrate, set `grant`, and go to PRE.
  - Round-robin: the source not granted last time wins ties; the last-grant pointer resets to 1, so source 0 wins the first tie.
- **PRE:** txen=1, txd=0x5 for `PREAMBLE_NIBBLES` cycles, then SFD.
- **SFD:** txen=1, txd=0xD; `req_ready[g]`=1.
  - If valid, latch data/last/err and go to DLO.
  - Otherwise it is an underflow.
- **DLO:** txen=1, txd=byte[3:0], txer=err. Go to DHI.
- **DHI:** txen=1, txd=byte[7:4], txer=err.
  - If the latched byte is last: `req_ready`=0, go to IPG.
  - Else `req_ready[g]`=1. If valid, latch the next byte and go to DLO; otherwise it is an underflow.
- **Underflow:**
  - Pulse `underflow`.
  - The next output cycle is txen=1, txer=1, txd=0 for exactly one nibble.
  - Then go to FLUSH.
- **FLUSH:** txen=0, `req_ready[g]`=1; discard bytes until one with `req_last` is accepted, then go to IPG.
- **IPG:** txen=0, `grant`=0; count `IPG_NIBBLES` cycles.
  - In the final cycle, arbitrate as in IDLE: on a request go to PRE, else go to IDLE.
- The other source's `req_ready` is 0 throughout.
- Reset values: txen=0, txer=0, txd=0, `req_ready`=0, `grant`=0, `underflow`=0, state IDLE, IPG counter 0.

## Timing
- Arbitration in cycle N puts the first preamble nibble on the pins in N+1.
- SFD is on the pins in N+1+`PREAMBLE_NIBBLES`.
- A byte accepted at edge E drives its low nibble in E+1 and its high nibble in E+2.
- Steady-state throughput is 1 byte per 2 cycles.
- Outputs with txen=0 are txer=0, txd=0.
- The gap between the last frame nibble (or error nibble) and the next preamble is exactly `IPG_NIBBLES` cycles when a request is pending; from IDLE it is ≥ `IPG_NIBBLES`.
- FLUSH cycles do not count toward the IPG; the IPG counter starts after `last` is accepted.
- A single-byte frame (`last` on the first byte) is SFD, DLO, DHI, then IPG.
- Both requesting at the IPG end: the non-previous source wins. Only one requesting: it wins regardless of pointer.
- `rstn` low mid-frame: outputs go to reset values at that edge (frame truncated, no txer nibble). A held-off source must re-present its frame from the start.
- A `req_valid` drop during PRE has no effect; underflow is evaluated only in SFD/DHI.

## Test plan
- **Single frame:** src0 bytes 0x21,0x43 (last) →
  - txd 5×15, D, 1,2,3,4;
  - txen for 20 cycles, txer=0;
  - `grant`=01 throughout.
- **Contention:** both sources valid at reset release, 2-byte frames each →
  - src0 frame, exactly 24 txen-low cycles, then src1 frame;
  - repeat gives src0 again.
- **Error byte:** src1 bytes 0x10, 0x32 with err, 0x54 last → txer=1 on exactly the nibbles 2,3.
- **Underflow:** src0 sends 0x10, then deasserts valid at the DHI ready →
  - `underflow` pulse;
  - one nibble txen=1/txer=1/txd=0;
  - then txen=0;
  - 3 further bytes (last on the 3rd) are accepted and dropped;
  - 24-cycle IPG.
- **Reset mid-frame:** `rstn`=0 during DLO of byte 3 →
  - next edge: txen=0, `grant`=0, `req_ready`=0;
  - after release, a new request is preceded by the full preamble.
- **Back-to-back same source:** src0 alone, two 1-byte frames (0xA5) → 5×15, D, 5, A; 24 low cycles; identical second frame.
